// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional feature macro used by fifo_wr_arbiter: WR_ARB_PKT_LOCK_EN.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Largest requester count the helpers below are sized for.
    localparam int MAX_NREQ = 16;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot to binary; an all-zero vector maps to 0.
    function automatic logic [3:0] oh2bin(input logic [MAX_NREQ-1:0] oh);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                b = b | 4'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, searching cyclically. Shared by the idle grant and the
// back-to-back re-arbitration path.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_found,
    output logic [NREQ-1:0] o_pick_oh,
    output logic [IW-1:0]   o_pick_idx
);

    // Cyclic scan from i_ptr; the first hit wins.
    always_comb begin : p_pick
        int          v_j;
        logic [IW-1:0] v_jx;
        o_found    = 1'b0;
        o_pick_oh  = '0;
        o_pick_idx = '0;
        v_j        = 0;
        v_jx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_j = int'(i_ptr) + i;
            if (v_j >= NREQ) begin
                v_j = v_j - NREQ;
            end
            v_jx = IW'(v_j);
            if (!o_found && i_req[v_jx]) begin
                o_found          = 1'b1;
                o_pick_oh[v_jx]  = 1'b1;
                o_pick_idx       = v_jx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters.
// Macro WR_ARB_PKT_LOCK_EN: when defined, a grant is held from the first
// beat until a transfer with i_req_last=1, and valid gaps do not release it.
//
// Handshake: a requester beat transfers on a rising edge when
// i_req_valid[k] & o_req_ready[k]; o_req_ready is only ever set for the
// granted requester and only while !i_full, so a requester transfer and a
// FIFO write (o_valid_s & !i_full) always happen in the same cycle.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = 32,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ*DW-1:0] i_req_data,
    input  logic [NREQ-1:0]    i_req_last,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic             i_full,
    input  logic             i_almostfull,
    output logic             o_valid_s,
    output logic [DW-1:0]    o_wdata,
    output logic [NREQ-1:0]  o_grant,
    output logic [IW-1:0]    o_gnt_id,
    output logic             o_busy,
    output state_t           o_dbg_state
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_grant_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_ptr_nxt;

    logic            w_found;
    logic [NREQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic [IW-1:0]   w_ptr_after;
    logic            w_arb_ok;
    logic            w_gnt_valid;
    logic            w_xfer;
    logic            w_release;
    logic            w_drop;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req      (i_req_valid),
        .i_ptr      (r_rr_ptr),
        .o_found    (w_found),
        .o_pick_oh  (w_pick_oh),
        .o_pick_idx (w_pick_idx)
    );

    // The winner becomes lowest priority next time: pointer moves just past it.
    assign w_ptr_after = (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
    // Almost-full only gates new grants, never an active one.
    assign w_arb_ok    = w_found & ~i_almostfull;
    assign w_gnt_valid = |(i_req_valid & r_grant);
    assign w_xfer      = w_gnt_valid & ~i_full;

`ifdef WR_ARB_PKT_LOCK_EN
    logic w_gnt_last;
    assign w_gnt_last = |(i_req_last & r_grant);
    assign w_release  = w_xfer & w_gnt_last;
    assign w_drop     = 1'b0;
`else
    logic w_unused_last;
    assign w_unused_last = ^i_req_last;
    assign w_release     = w_xfer;
    assign w_drop        = ~w_gnt_valid;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Next-state: grant from idle, re-arbitrate at release, drop on a valid gap.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_arb_ok) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick_oh;
                    w_ptr_nxt   = w_ptr_after;
                end
            end
            GRANT: begin
                if (w_release) begin
                    if (w_arb_ok) begin
                        w_grant_nxt = w_pick_oh;
                        w_ptr_nxt   = w_ptr_after;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (w_drop) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Write-data mux: granted requester straight through, zero when idle.
    always_comb begin
        o_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                o_wdata = i_req_data[k*DW +: DW];
            end
        end
    end

    assign o_req_ready = r_grant & {NREQ{~i_full}};
    assign o_valid_s   = w_gnt_valid;
    assign o_grant     = r_grant;
    assign o_gnt_id    = IW'(oh2bin(MAX_NREQ'(r_grant)));
    assign o_busy      = (r_state == GRANT);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a scoreboard on the FIFO side.
// Honours WR_ARB_PKT_LOCK_EN to select the matching directed sequence.
module tb_fifo_wr_arbiter;
    import fifo_wr_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               full;
    logic               af;
    logic               valid_s;
    logic [DW-1:0]      wdata;
    logic [NREQ-1:0]    grant;
    logic [1:0]         gnt_id;
    logic               busy;
    state_t             dbg_state;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .i_req_last   (req_last),
        .o_req_ready  (req_ready),
        .i_full       (full),
        .i_almostfull (af),
        .o_valid_s    (valid_s),
        .o_wdata      (wdata),
        .o_grant      (grant),
        .o_gnt_id     (gnt_id),
        .o_busy       (busy),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- bench state ----------------
    logic [DW:0]     src_q [NREQ][$];   // {last, data} per requester
    logic [DW-1:0]   exp_q [$];         // expected FIFO write order
    logic [NREQ-1:0] gap;
    logic [NREQ-1:0] xfer;
    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int n_xfer     = 0;
    int first_xfer = 0;
    int last_xfer  = 0;

    function automatic logic [DW-1:0] beat(input int k, input int b);
        return {8'hA0, 8'(k), 16'(b)};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() > 0 && !gap[k]) begin
                req_valid[k]            = 1'b1;
                req_data[k*DW +: DW]    = src_q[k][0][DW-1:0];
                req_last[k]             = src_q[k][0][DW];
            end else begin
                req_valid[k]            = 1'b0;
                req_data[k*DW +: DW]    = '0;
                req_last[k]             = 1'b0;
            end
        end
    endtask

    // Advance one clock, retire beats accepted at that edge, re-drive inputs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (xfer[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic load(input int k, input int n);
        for (int b = 0; b < n; b++) src_q[k].push_back({(b == n - 1), beat(k, b)});
        drive();
        #1;
    endtask

    task automatic expect_beat(input int k, input int b);
        exp_q.push_back(beat(k, b));
    endtask

    task automatic drain(input string name, input int max_cyc);
        for (int t = 0; t < max_cyc; t++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check(name, DW'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NREQ; k++) src_q[k].delete();
        gap = '0;
        drive();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [NREQ-1:0] src_x;
        logic            wr;
        src_x = req_valid & req_ready;
        wr    = valid_s & ~full;
        xfer <= rst_n ? src_x : '0;
        if (rst_n && (wr || (|src_x))) begin
            check("port_xfer_agree", DW'(wr), DW'(|src_x));
            if (wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", wdata, '0);
                    if (wdata == '0) begin
                        n_errors++;
                        $display("FAIL unexpected_beat: got %h expected none", wdata);
                    end
                end else begin
                    check("fifo_beat", wdata, exp_q.pop_front());
                end
                if (n_xfer == 0) first_xfer = cyc;
                last_xfer = cyc;
                n_xfer++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        full  = 1'b0;
        af    = 1'b0;
        gap   = '0;
        xfer  = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",   DW'(grant),   '0);
        check("rst_gnt_id",  DW'(gnt_id),  '0);
        check("rst_busy",    DW'(busy),    '0);
        check("rst_ready",   DW'(req_ready), '0);
        check("rst_valid_s", DW'(valid_s), '0);
        check("rst_wdata",   wdata,        '0);
        check("rst_state",   DW'(dbg_state), DW'(IDLE));
        rst_n = 1'b1;
        step();

`ifndef WR_ARB_PKT_LOCK_EN
        // Simultaneous 0 and 2: grant 0, then 2 back-to-back.
        load(0, 1); load(2, 1);
        expect_beat(0, 0); expect_beat(2, 0);
        step();
        check("t2_grant0",  DW'(grant),  DW'(4'b0001));
        check("t2_id0",     DW'(gnt_id), DW'(0));
        check("t2_busy",    DW'(busy),   DW'(1));
        check("t2_ready0",  DW'(req_ready), DW'(4'b0001));
        check("t2_wdata0",  wdata,       beat(0, 0));
        step();
        check("t2_grant2",  DW'(grant),  DW'(4'b0100));
        check("t2_id2",     DW'(gnt_id), DW'(2));
        step();
        step();
        check("t2_idle",    DW'(busy),   '0);
        check("t2_idle_gnt", DW'(grant), '0);
        drain("t2_drain", 5);

        // All four continuously valid, pointer now 3: order 3,0,1,2 repeating.
        n_xfer = 0;
        load(0, 3); load(1, 3); load(2, 3); load(3, 3);
        for (int b = 0; b < 3; b++) begin
            expect_beat(3, b); expect_beat(0, b); expect_beat(1, b); expect_beat(2, b);
        end
        step();
        check("t3_first_grant", DW'(grant), DW'(4'b1000));
        drain("t3_drain", 20);
        check("t3_beats",      DW'(n_xfer), DW'(12));
        check("t3_throughput", DW'(last_xfer - first_xfer), DW'(11));
        step(); step();
        check("t3_idle", DW'(busy), '0);

        // Full for three cycles in the middle of requester 1's stream.
        n_xfer = 0;
        load(1, 3);
        for (int b = 0; b < 3; b++) expect_beat(1, b);
        step();
        check("t4_grant1", DW'(grant), DW'(4'b0010));
        step();
        full = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t4_full_ready", DW'(req_ready), '0);
            check("t4_full_grant", DW'(grant), DW'(4'b0010));
            step();
        end
        full = 1'b0;
        #1;
        drain("t4_drain", 10);
        check("t4_beats", DW'(n_xfer), DW'(3));
        step(); step();

        // Almost-full blocks a grant from idle; release grants next cycle.
        af = 1'b1;
        load(0, 1); load(3, 1);
        expect_beat(3, 0); expect_beat(0, 0);
        step();
        check("t5_af_nogrant", DW'(grant), '0);
        step();
        check("t5_af_idle", DW'(busy), '0);
        af = 1'b0;
        #1;
        step();
        check("t5_grant3", DW'(grant), DW'(4'b1000));
        drain("t5_drain", 10);
        step(); step();

        // Reset in the middle of requester 2's stream.
        load(2, 4);
        expect_beat(2, 0);
        step();
        check("t6_grant2", DW'(grant), DW'(4'b0100));
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_grant",   DW'(grant),   '0);
        check("t6_rst_valid_s", DW'(valid_s), '0);
        check("t6_rst_busy",    DW'(busy),    '0);
        check("t6_rst_ready",   DW'(req_ready), '0);
        clear_sources();
        check("t6_rst_beats", DW'(exp_q.size()), '0);
        step();
        rst_n = 1'b1;
        step();
        load(1, 1); load(3, 1);
        expect_beat(1, 0); expect_beat(3, 0);
        step();
        check("t6_restart_grant", DW'(grant), DW'(4'b0010));
        drain("t6_drain", 10);
`else
        // Locked 4-beat packet from 1 with a 2-cycle gap; 0 waits.
        load(1, 4);
        for (int b = 0; b < 4; b++) expect_beat(1, b);
        expect_beat(0, 0);
        step();
        check("l1_grant1", DW'(grant), DW'(4'b0010));
        load(0, 2);
        step();
        gap[1] = 1'b1;
        drive();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("l1_gap_grant", DW'(grant), DW'(4'b0010));
            check("l1_gap_valid", DW'(valid_s), '0);
            step();
        end
        gap[1] = 1'b0;
        drive();
        #1;
        drain("l1_drain", 20);

        // Reset while requester 0 is mid-packet.
        check("l2_mid_grant", DW'(grant), DW'(4'b0001));
        rst_n = 1'b0;
        #1;
        check("l2_rst_grant",   DW'(grant),   '0);
        check("l2_rst_valid_s", DW'(valid_s), '0);
        check("l2_rst_busy",    DW'(busy),    '0);
        clear_sources();
        step();
        rst_n = 1'b1;
        step();
        load(0, 1); load(3, 1);
        expect_beat(0, 0); expect_beat(3, 0);
        step();
        check("l2_restart_grant", DW'(grant), DW'(4'b0001));
        drain("l2_drain", 10);
`endif

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stall expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the synchronous FIFO among NREQ independent requesters. It sits directly in front of the FIFO write controller and drives its write-request and write-data inputs. It uses the controller's full and almost-full flags for backpressure and to decide when to issue a grant. Optional packet locking holds a grant until the requester's last beat, so multi-beat packets are never interleaved in the FIFO.

## Interface
- NREQ, 4, number of requesters (2..16)
- DW, 32, write data width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous reset, active low
- i_req_valid  in  NREQ  per-requester data valid
- i_req_data  in  NREQ×DW  per-requester write data, packed, requester k at [k*DW +: DW]
- i_req_last  in  NREQ  per-requester last beat of packet (used only with lock)
- o_req_ready  out  NREQ  per-requester accept; a beat transfers when valid & ready
- i_full  in  1  FIFO full flag
- i_almostfull  in  1  FIFO almost-full flag
- o_valid_s  out  1  write request to FIFO write controller
- o_wdata  out  DW  write data to FIFO
- o_grant  out  NREQ  one-hot current grant, registered
- o_gnt_id  out  $clog2(NREQ)  binary index of current grant, 0 when idle
- o_busy  out  1  a grant is active

## Operation
- FSM, two states: IDLE, GRANT. Reset state IDLE.
- Reset values: o_grant=0, o_gnt_id=0, o_busy=0, o_req_ready=0, o_valid_s=0, o_wdata=0, rr_ptr=0.
- In IDLE: if any i_req_valid and !i_almostfull, pick the first valid requester at or after rr_ptr (cyclic), go to GRANT. Set o_grant to that requester's one-hot, and set rr_ptr <= (k+1) mod NREQ.
- In GRANT (requester g): o_valid_s = i_req_valid[g]; o_wdata = i_req_data[g]; o_req_ready[g] = !i_full; all other ready bits are 0.
- Release point: a transfer (i_req_valid[g] & !i_full) that ends the grant. Without lock this is every transfer. With lock it is a transfer with i_req_last[g]=1.
- At the release point: if any i_req_valid and !i_almostfull, re-arbitrate from rr_ptr and enter the new grant next cycle (back-to-back, no dead cycle). Otherwise go to IDLE.
- Requester g's own valid is included in re-arbitration. It is lowest priority because rr_ptr=g+1.
- Without lock: if i_req_valid[g]=0 while in GRANT, return to IDLE next cycle.
- With lock: a valid gap mid-packet holds the grant.
- i_full in GRANT: ready is low and the grant is held; the grant is never revoked by full.
- i_almostfull only blocks new grants. An active grant, including a locked packet, continues until i_full.
- o_valid_s may be high while i_full=1. The write controller gates the write.

## Timing
- Grant latency: request in cycle n with FIFO not almost-full gives o_grant in cycle n+1 from IDLE.
- Data path from i_req_data[g] to o_wdata is combinational, with no pipeline latency.
- Sustained throughput is 1 beat/cycle across grant changes (back-to-back re-arbitration).
- Reset mid-operation: all outputs return to reset values asynchronously. Any partial packet is abandoned; the requester must resend.
- Simultaneous requests: exactly one grant; order is round-robin from rr_ptr.
- rr_ptr wraps from NREQ-1 to 0.

## Configuration
- WR_ARB_PKT_LOCK_EN defined: the grant is held from first beat until a transfer with i_req_last=1, and valid gaps do not release it.
- WR_ARB_PKT_LOCK_EN undefined: every transfer is a release point, i_req_last is ignored, and a valid gap releases the grant.

## Structure
- Package fifo_wr_arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam function for index width ($clog2 with a minimum of 1)
  - one-hot-to-binary function
- Sub-module rr_pick:
  - purely combinational
  - inputs: request vector and rr_ptr
  - outputs: found flag, one-hot pick and binary index
  - used for both the IDLE grant and re-arbitration

## Test plan
- Reset, then requesters 0 and 2 valid simultaneously → grant 0 in cycle 1; after its transfer grant 2 with no idle cycle; rr_ptr then 3.
- All 4 requesters continuously valid, lock off, FIFO never full → grants 0,1,2,3,0… one beat each, 1 beat/cycle.
- Lock on, requester 1 sends a 4-beat packet with a 2-cycle valid gap while requester 0 is valid → FIFO receives 4 contiguous beats of requester 1 before any of requester 0.
- i_full asserted for 3 cycles mid-grant → o_req_ready[g]=0 those cycles; grant unchanged; no beat lost or duplicated.
- i_almostfull=1 in IDLE with requests pending → no grant. Then deassert → grant issued next cycle.
- Reset asserted mid-packet (lock on) → o_grant=0, o_valid_s=0 immediately; after release, arbitration restarts with requester 0 highest priority.
